// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg : shared types and constants for the sequence-detector chain
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } seq_state_e;

  // Level held on the serial line between words; detector benches share it.
  localparam logic SEQ_IDLE_BIT = 1'b0;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/seq_bit_counter.sv
// ============================================================================
// seq_bit_counter : modulo-WIDTH bit counter with sync clear, enable and last
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_bit_counter #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_o = (cnt_q == C_LAST);
  assign cnt_o  = cnt_q;

  // Clear wins over enable; wrapping at WIDTH-1 keeps the count in range.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : seq_bit_counter

`default_nettype wire

// File: rtl/seq_bit_serializer.sv
// ============================================================================
// seq_bit_serializer : valid/ready word in, one bit per clock out on w
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   LSB_FIRST = 1'b0,
  parameter logic IDLE_BIT  = SEQ_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             clear,
  output logic             w,
  output logic             w_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shifted;
  logic             head_bit;
  logic [CW-1:0]    bit_cnt;
  logic             cnt_last;
  logic             shifting;
  logic             accept;

  assign shifting = (state_q == S_SHIFT);

  // A new word is only taken while idle or on the final bit of the current one.
  assign din_ready = !clear && (!shifting || cnt_last);
  assign accept    = din_valid && din_ready;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign head_bit = shreg_q[0];
      assign shifted  = {IDLE_BIT, shreg_q[WIDTH-1:1]};
    end else begin : g_msb_first
      assign head_bit = shreg_q[WIDTH-1];
      assign shifted  = {shreg_q[WIDTH-2:0], IDLE_BIT};
    end
  endgenerate

  seq_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (clear || !shifting),
    .en_i   (shifting),
    .cnt_o  (bit_cnt),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt_last && !accept) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (accept) begin
        shreg_d = din;
      end else if (shifting) begin
        shreg_d = shifted;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shreg_q <= {WIDTH{IDLE_BIT}};
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // Outputs come from flops only, so the detector sees no input-to-output path.
  assign busy      = shifting;
  assign w_valid   = shifting;
  assign w         = shifting ? head_bit : IDLE_BIT;
  assign word_done = shifting && (bit_cnt == CW'(WIDTH - 1));

endmodule : seq_bit_serializer

`default_nettype wire

// File: tb/tb_seq_bit_serializer.sv
// ============================================================================
// tb_seq_bit_serializer : random traffic on two serializer configurations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_bit_serializer;

  localparam int W0 = 4;
  localparam int W1 = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] dinm [2];
  logic        vld  [2];
  logic        pend [2];
  logic        acc  [2];
  logic [4:0]  obs  [2];

  logic din_ready0, w0, w_valid0, word_done0, busy0;
  logic din_ready1, w1, w_valid1, word_done1, busy1;

  seq_bit_serializer #(.WIDTH(W0), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_msb (
    .clk       (clk),
    .reset     (reset),
    .din       (dinm[0][W0-1:0]),
    .din_valid (vld[0]),
    .din_ready (din_ready0),
    .clear     (clear),
    .w         (w0),
    .w_valid   (w_valid0),
    .word_done (word_done0),
    .busy      (busy0)
  );

  seq_bit_serializer #(.WIDTH(W1), .LSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_lsb (
    .clk       (clk),
    .reset     (reset),
    .din       (dinm[1][W1-1:0]),
    .din_valid (vld[1]),
    .din_ready (din_ready1),
    .clear     (clear),
    .w         (w1),
    .w_valid   (w_valid1),
    .word_done (word_done1),
    .busy      (busy1)
  );

  assign obs[0] = {din_ready0, w0, w_valid0, word_done0, busy0};
  assign obs[1] = {din_ready1, w1, w_valid1, word_done1, busy1};

  // Reference: the word in flight and how many of its bits are still to appear.
  int          wid  [2] = '{W0, W1};
  bit          lsbf [2] = '{1'b0, 1'b1};
  logic        idl  [2] = '{1'b0, 1'b1};
  int          rem  [2];
  int          idx  [2];
  logic [31:0] word [2];
  int          nword0;
  logic [31:0] dir_words [2] = '{32'hB, 32'h6};

  int nvec = 0;
  int nerr = 0;

  task automatic check_vec(input string tag, input logic [4:0] got, input logic [4:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t {ready,w,w_valid,word_done,busy} got %b expected %b",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [4:0] expect_of(input int i);
    logic in_word;
    logic bitv;
    logic rdy;
    in_word = (rem[i] > 0);
    if (!in_word)     bitv = idl[i];
    else if (lsbf[i]) bitv = word[i][idx[i]];
    else              bitv = word[i][wid[i]-1-idx[i]];
    rdy = !clear && (rem[i] <= 1);
    return {rdy, bitv, in_word, (rem[i] == 1), in_word};
  endfunction

  initial begin
    nword0 = 0;
    for (int i = 0; i < 2; i++) begin
      dinm[i] = '0; vld[i] = 1'b0; pend[i] = 1'b0; acc[i] = 1'b0;
      rem[i]  = 0;  idx[i] = 0;    word[i] = '0;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_vec("reset_msb", obs[0], expect_of(0));
    check_vec("reset_lsb", obs[1], expect_of(1));
    @(negedge clk);
    reset = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      clear = (cyc > 40) && ($urandom_range(0, 99) < 4);
      reset = !((cyc > 40) && ($urandom_range(0, 199) == 0));
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          if (i == 0 && nword0 < 2) begin
            vld[i]  = 1'b1;
            dinm[i] = dir_words[nword0];
          end else begin
            vld[i]  = ($urandom_range(0, 9) < 7);
            dinm[i] = $urandom;
          end
        end
        if (!reset) rem[i] = 0;
      end
      #1;
      check_vec("cyc_msb", obs[0], expect_of(0));
      check_vec("cyc_lsb", obs[1], expect_of(1));
      for (int i = 0; i < 2; i++) begin
        logic [4:0] e;
        e = expect_of(i);
        acc[i] = reset && vld[i] && e[4];
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!reset || clear) begin
          rem[i] = 0;
        end else begin
          if (rem[i] > 0) begin
            rem[i]--;
            idx[i]++;
          end
          if (acc[i]) begin
            word[i] = dinm[i];
            rem[i]  = wid[i];
            idx[i]  = 0;
            if (i == 0) nword0++;
          end
        end
        pend[i] = vld[i] && !acc[i];
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_seq_bit_serializer

`default_nettype wire
